terminal_input_capture: RTL and testbench
=========================================

// Module: terminal_input_capture
// PURPOSE
//  Upstream input stage for the access-control core (pbl). Two raw terminals
//  (switches HHx, active-low buttons Bx) are synchronised and debounced per
//  terminal. A request is frozen for a fixed hold window, then the core inputs
//  return to idle. The core's LEDs, matrix and 7-seg therefore see stable,
//  single-shot requests instead of bouncing live switches.
// PARAMETERS
//  DEB_CYCLES   500000     stable cycles needed to accept a press/release (>=2)
//  HOLD_CYCLES  150000000  cycles a captured request is presented to core (>=1)
//  CNT_W        28         counter width; must hold max(DEB_CYCLES,HOLD_CYCLES)-1
// PORTS
//  CLK       in   1  system clock, all logic on rising edge
//  RST       in   1  synchronous reset, active-high
//  HH0_IN    in   4  terminal 0 raw switches {user[2:0], func_bit}
//  HH1_IN    in   4  terminal 1 raw switches
//  B0_IN     in   2  terminal 0 raw buttons, active-low (released = 2'b11)
//  B1_IN     in   2  terminal 1 raw buttons, active-low
//  HH0       out  4  to core HH0; held request or 4'b0000 when idle
//  HH1       out  4  to core HH1
//  B0        out  2  to core B0; held buttons or 2'b11 when idle
//  B1        out  2  to core B1
//  VALID0    out  1  high while terminal 0 request is presented
//  VALID1    out  1  high while terminal 1 request is presented
// BEHAVIOUR
//  - Sync: 2-FF chain on all raw inputs. Sync regs reset to HH=0, B=2'b11.
//  - Each terminal has an independent FSM with no cross-terminal arbitration.
//    Both terminals may be VALID together; the core resolves conflicts.
//  - IDLE: outputs idle, VALID=0. If synced B!=2'b11, snapshot Bsnap=B, cnt=0,
//    and go to DEBOUNCE.
//  - DEBOUNCE: if synced B!=Bsnap, go to IDLE (bounce/changed press). Else if
//    cnt==DEB_CYCLES-1, register HH<=synced HH and B<=Bsnap, set VALID=1,
//    cnt=0, and go to HOLD. Else cnt++.
//  - HOLD: outputs frozen; switch/button changes are ignored. When
//    cnt==HOLD_CYCLES-1, set outputs to idle, VALID=0, cnt=0, and go to
//    WAIT_REL. VALID is high for exactly HOLD_CYCLES cycles.
//  - WAIT_REL: no new capture. cnt counts consecutive cycles with synced
//    B==2'b11 and clears on any press. Go to IDLE when cnt==DEB_CYCLES-1.
//    A held button never auto-repeats.
//  - Latency: edge 1 = first edge at which sync stage 1 samples the new level.
//    VALID and outputs change after edge DEB_CYCLES+3.
//  - Both buttons pressed (2'b00) are captured as-is. Only a change from the
//    snapshot restarts debounce, so 2'b10 then 2'b00 restarts.
//  - All outputs are registered, with no combinational path from inputs.
//  - Reset: all FSMs go to IDLE, cnt=0, HH*=4'b0000, B*=2'b11, VALID*=0 after
//    the first RST-high edge, including mid-DEBOUNCE or mid-HOLD.
// STRUCTURE
//  - Shared include pbl_defs.vh holds the FSM state encodings
//    (IDLE/DEBOUNCE/HOLD/WAIT_REL, 2 bits), B_IDLE=2'b11 and HH_IDLE=4'b0000.
//  - Sub-module terminal_capture contains sync, FSM, counter and output regs
//    for one terminal, with the same parameters. It is instantiated twice.
//  - The top level is wiring only.
// TESTING (DEB_CYCLES=4, HOLD_CYCLES=8)
//  - Clean press: HH0_IN=4'b1011, B0_IN 11->01 held -> VALID0 rises after
//    edge 7, HH0=1011, B0=01 for 8 cycles, then HH0=0000, B0=11.
//  - Bounce: B0_IN toggles 01/11 every 2 cycles for 20 cycles -> VALID0 stays
//    0. A stable press afterwards is accepted normally.
//  - Hold and repeat: button kept at 01 past HOLD end, HH0_IN changed during
//    HOLD -> outputs unchanged in HOLD, no second VALID0 until 4 released
//    cycles, then a new press.
//  - Simultaneous: both terminals press on the same edge with different HH ->
//    VALID0 and VALID1 rise on the same edge, each with its own HH and B.
//  - Reset mid-HOLD: RST high for 1 cycle at HOLD cycle 3 -> next edge
//    VALID0=0, HH0=0000, B0=11. A stable press after reset needs the full
//    DEB_CYCLES+3 again.
//  - Release glitch in WAIT_REL: 11,11,01,11,11,11,11 -> IDLE reached only
//    after 4 consecutive 11 samples.

Source files
------------

// File: rtl/terminal_input_capture_pkg.sv
// rtl/terminal_input_capture_pkg.sv - shared state encodings and idle values for terminal capture
package terminal_input_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_WAIT_REL = 2'd3
    } cap_state_e;

    localparam logic [1:0] B_IDLE  = 2'b11;
    localparam logic [3:0] HH_IDLE = 4'b0000;

endpackage

// File: rtl/terminal_capture.sv
// rtl/terminal_capture.sv - one terminal: 2-FF sync, debounce, fixed hold window, release wait
module terminal_capture
    import terminal_input_capture_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 150000000,
    parameter int CNT_W       = 28
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] hh_raw_i,
    input  logic [1:0] b_raw_i,
    output logic [3:0] hh_o,
    output logic [1:0] b_o,
    output logic       valid_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [3:0]       hh_s1_q, hh_s2_q;
    logic [1:0]       b_s1_q, b_s2_q;
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bsnap_q, bsnap_d;
    logic [3:0]       hh_q, hh_d;
    logic [1:0]       b_q, b_d;
    logic             valid_q, valid_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hh_s1_q <= HH_IDLE;
            hh_s2_q <= HH_IDLE;
            b_s1_q  <= B_IDLE;
            b_s2_q  <= B_IDLE;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bsnap_q <= B_IDLE;
            hh_q    <= HH_IDLE;
            b_q     <= B_IDLE;
            valid_q <= 1'b0;
        end else begin
            hh_s1_q <= hh_raw_i;
            hh_s2_q <= hh_s1_q;
            b_s1_q  <= b_raw_i;
            b_s2_q  <= b_s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bsnap_q <= bsnap_d;
            hh_q    <= hh_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    // Only a change away from the snapshot aborts debounce, so 2'b00 is a legal capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bsnap_d = bsnap_q;
        hh_d    = hh_q;
        b_d     = b_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (b_s2_q != B_IDLE) begin
                    bsnap_d = b_s2_q;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (b_s2_q != bsnap_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    hh_d    = hh_s2_q;
                    b_d     = bsnap_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    hh_d    = HH_IDLE;
                    b_d     = B_IDLE;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (b_s2_q != B_IDLE) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hh_o    = hh_q;
    assign b_o     = b_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/terminal_input_capture.sv
// rtl/terminal_input_capture.sv - two independent terminal capture channels feeding the core
module terminal_input_capture
    import terminal_input_capture_pkg::*;
#(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 150000000,
    parameter int CNT_W       = 28
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] HH0_IN,
    input  logic [3:0] HH1_IN,
    input  logic [1:0] B0_IN,
    input  logic [1:0] B1_IN,
    output logic [3:0] HH0,
    output logic [3:0] HH1,
    output logic [1:0] B0,
    output logic [1:0] B1,
    output logic       VALID0,
    output logic       VALID1
);

    terminal_capture #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_term0 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .hh_raw_i(HH0_IN),
        .b_raw_i (B0_IN),
        .hh_o    (HH0),
        .b_o     (B0),
        .valid_o (VALID0)
    );

    terminal_capture #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_term1 (
        .clk_i   (CLK),
        .rst_i   (RST),
        .hh_raw_i(HH1_IN),
        .b_raw_i (B1_IN),
        .hh_o    (HH1),
        .b_o     (B1),
        .valid_o (VALID1)
    );

endmodule

// File: tb/tb_terminal_input_capture.sv
// tb/tb_terminal_input_capture.sv - directed self-checking bench for terminal_input_capture
module tb_terminal_input_capture;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] HH0_IN, HH1_IN;
    logic [1:0] B0_IN, B1_IN;
    logic [3:0] HH0, HH1;
    logic [1:0] B0, B1;
    logic       VALID0, VALID1;

    int n_cmp = 0;
    int n_err = 0;

    terminal_input_capture #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(8),
        .CNT_W      (4)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .HH0_IN(HH0_IN),
        .HH1_IN(HH1_IN),
        .B0_IN (B0_IN),
        .B1_IN (B1_IN),
        .HH0   (HH0),
        .HH1   (HH1),
        .B0    (B0),
        .B1    (B1),
        .VALID0(VALID0),
        .VALID1(VALID1)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_t0(input string tag, input logic v, input logic [3:0] hh, input logic [1:0] b);
        chk({tag, ".valid0"}, {3'b0, VALID0}, {3'b0, v});
        chk({tag, ".hh0"}, HH0, hh);
        chk({tag, ".b0"}, {2'b0, B0}, {2'b0, b});
    endtask

    task automatic chk_t1(input string tag, input logic v, input logic [3:0] hh, input logic [1:0] b);
        chk({tag, ".valid1"}, {3'b0, VALID1}, {3'b0, v});
        chk({tag, ".hh1"}, HH1, hh);
        chk({tag, ".b1"}, {2'b0, B1}, {2'b0, b});
    endtask

    initial begin
        RST = 1'b1; HH0_IN = 4'b0000; HH1_IN = 4'b0000; B0_IN = 2'b11; B1_IN = 2'b11;
        tick(2);
        RST = 1'b0;
        chk_t0("reset", 1'b0, 4'b0000, 2'b11);
        chk_t1("reset", 1'b0, 4'b0000, 2'b11);

        // clean press: visible after edge 7, held 8 cycles
        HH0_IN = 4'b1011; B0_IN = 2'b01;
        tick(6);
        chk_t0("clean.e6", 1'b0, 4'b0000, 2'b11);
        tick(1);
        chk_t0("clean.e7", 1'b1, 4'b1011, 2'b01);
        tick(7);
        chk_t0("clean.e14", 1'b1, 4'b1011, 2'b01);
        tick(1);
        chk_t0("clean.e15", 1'b0, 4'b0000, 2'b11);
        B0_IN = 2'b11;
        tick(8);

        // bounce: 01/11 every 2 cycles never completes debounce
        for (int i = 0; i < 10; i++) begin
            B0_IN = i[0] ? 2'b11 : 2'b01;
            tick(1);
            chk("bounce", {3'b0, VALID0}, 4'b0000);
            tick(1);
            chk("bounce", {3'b0, VALID0}, 4'b0000);
        end

        // stable press after bounce, then hold-and-repeat
        HH0_IN = 4'b0110; B0_IN = 2'b01;
        tick(6);
        chk_t0("post_bounce.e6", 1'b0, 4'b0000, 2'b11);
        tick(1);
        chk_t0("post_bounce.e7", 1'b1, 4'b0110, 2'b01);
        HH0_IN = 4'b1111;
        tick(3);
        chk_t0("hold_frozen", 1'b1, 4'b0110, 2'b01);
        tick(5);
        chk_t0("hold_end", 1'b0, 4'b0000, 2'b11);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("no_repeat", {3'b0, VALID0}, 4'b0000);
        end
        B0_IN = 2'b11;
        tick(8);
        chk("released", {3'b0, VALID0}, 4'b0000);
        HH0_IN = 4'b0001; B0_IN = 2'b10;
        tick(6);
        chk("repress.e6", {3'b0, VALID0}, 4'b0000);
        tick(1);
        chk_t0("repress.e7", 1'b1, 4'b0001, 2'b10);
        tick(8);
        chk_t0("repress.end", 1'b0, 4'b0000, 2'b11);
        B0_IN = 2'b11;
        tick(8);

        // simultaneous press on both terminals, including both-buttons 2'b00
        HH0_IN = 4'b0011; B0_IN = 2'b00; HH1_IN = 4'b1100; B1_IN = 2'b10;
        tick(6);
        chk("simul.e6.v0", {3'b0, VALID0}, 4'b0000);
        chk("simul.e6.v1", {3'b0, VALID1}, 4'b0000);
        tick(1);
        chk_t0("simul.e7", 1'b1, 4'b0011, 2'b00);
        chk_t1("simul.e7", 1'b1, 4'b1100, 2'b10);
        tick(8);
        chk_t0("simul.end", 1'b0, 4'b0000, 2'b11);
        chk_t1("simul.end", 1'b0, 4'b0000, 2'b11);
        B0_IN = 2'b11; B1_IN = 2'b11;
        tick(8);

        // reset mid-HOLD, then the held press needs the full latency again
        HH0_IN = 4'b0101; B0_IN = 2'b01;
        tick(7);
        chk_t0("prerst", 1'b1, 4'b0101, 2'b01);
        tick(2);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk_t0("midhold_rst", 1'b0, 4'b0000, 2'b11);
        tick(6);
        chk("afterrst.e6", {3'b0, VALID0}, 4'b0000);
        tick(1);
        chk_t0("afterrst.e7", 1'b1, 4'b0101, 2'b01);
        tick(8);
        chk("afterrst.end", {3'b0, VALID0}, 4'b0000);

        // release glitch: 3 released samples after a glitch are not enough
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b01; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("short_release", {3'b0, VALID0}, 4'b0000);
        end

        // 11,11,01,11,11,11,11 then press: IDLE reached, capture after 14 edges
        HH0_IN = 4'b1001;
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b01; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b11; tick(1);
        B0_IN = 2'b01;
        tick(6);
        chk("glitch.e13", {3'b0, VALID0}, 4'b0000);
        tick(1);
        chk_t0("glitch.e14", 1'b1, 4'b1001, 2'b01);
        tick(8);
        chk("glitch.end", {3'b0, VALID0}, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
